mem_line_engine: RTL
====================

Name: mem_line_engine

Overview:
- Initiator-side driver for the team's single-port-write / single-port-read synchronous `Memory` block, used by the cache controller to move whole cache lines.
- Accepts one line request at a time (fill = read, writeback = write) over a valid/ready handshake.
- Drives the memory's write_en/waddr/wdata/raddr pins, tracks the memory's fixed one-cycle read latency, and streams beats in or out with backpressure.

Parameters:
- ADDR_W, 10, memory word-address width; memory depth 2**ADDR_W.
- DATA_W, 64, word width, equal to the memory data width.
- BEATS, 4, words per line; power of two, 2..2**ADDR_W. BW = $clog2(BEATS), LINE_W = ADDR_W-BW.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  line request valid.
- req_ready  out  1  engine idle, request accepted on valid&ready.
- req_write  in  1  1 = writeback, 0 = fill.
- req_line  in  LINE_W  line index.
- req_word  in  BW  critical word (optional feature only).
- wd_valid  in  1  writeback beat valid.
- wd_ready  out  1  writeback beat accepted.
- wd_data  in  DATA_W  writeback beat.
- rd_valid  out  1  fill beat valid.
- rd_ready  in  1  fill beat consumed.
- rd_data  out  DATA_W  fill beat.
- rd_last  out  1  final beat of the line.
- done  out  1  one-cycle pulse at request completion.
- mem_we  out  1  to memory write_en.
- mem_waddr  out  ADDR_W+1  to memory waddr; MSB always 0.
- mem_wdata  out  DATA_W  to memory wdata.
- mem_raddr  out  ADDR_W+1  to memory raddr; MSB always 0.
- mem_rdata  in  DATA_W  from memory rdata; valid one cycle after raddr is presented.

Behaviour:
- Reset values: state IDLE, req_ready=1, wd_ready=0, rd_valid=0, rd_last=0, done=0, mem_we=0, mem_waddr=0, mem_wdata=0, mem_raddr=0, rd_data=0. Beat counter, FIFO and in-flight flag are cleared.
- FSM states: IDLE, WRITE, READ.
  - IDLE->WRITE on accept with req_write=1.
  - IDLE->READ on accept with req_write=0.
  - WRITE->IDLE the cycle after the last mem_we.
  - READ->IDLE the cycle after the rd_last handshake.
- req_ready = (state==IDLE). The request is latched on acceptance. req_valid is ignored in every other state.
- Word address = {1'b0, line, beat}. Beat counts 0..BEATS-1; see the optional feature for wrap.
- WRITE:
  - wd_ready=1 throughout the state.
  - A beat handshake in cycle t registers mem_we=1, mem_waddr and mem_wdata for cycle t+1. The memory commits at the end of t+1.
  - mem_we=0 in any cycle with no handshake in the prior cycle. Gaps in wd_valid are allowed.
  - done=1 in the same cycle as the final mem_we. wd_ready=0 after the last beat is accepted.
- READ:
  - Beat i is issued by presenting mem_raddr in cycle c. mem_rdata is captured into a 2-entry FIFO at the end of c+1.
  - A single in-flight flag tracks the outstanding read.
  - Issue is allowed when fifo_count + inflight - (rd_valid&rd_ready) < 2, so an entry popped this cycle counts as free.
  - With rd_ready held high, beats stream one per cycle: accept in cycle 0, first issue in cycle 1, first rd_valid in cycle 3.
  - rd_valid = FIFO not empty; rd_data and rd_last come from the FIFO head.
  - rd_ready low: issue stalls with at most 2 beats held. There is no loss and no reordering.
  - done=1 in the cycle rd_valid&rd_ready&rd_last.
- mem_raddr holds its last value when not issuing; the memory read result is captured only when the in-flight flag is set.
- wd_valid outside WRITE and rd_ready outside READ are ignored.
- Reset mid-operation: all state is cleared asynchronously and buffered beats are discarded. mem_we drops immediately, so memory keeps any already-committed beats (the line is partial). The next request starts at its beat 0.

Optional Feature:
- Macro: MEM_LINE_ENGINE_CWF_EN (critical-word-first for fills).
- Defined: a READ starts at beat req_word and wraps modulo BEATS, e.g. BEATS=4, req_word=2 gives beats 2,3,0,1. rd_last marks the 4th beat issued.
- Undefined: req_word is ignored and reads start at beat 0.
- WRITE order is always 0..BEATS-1.

Test Plan:
1. Reset, then writeback line 5 with wd_valid high and data 0x11,0x22,0x33,0x44 -> mem_we high 4 consecutive cycles, waddr 20,21,22,23, done with the 4th mem_we, req_ready back high the next cycle.
2. Fill line 5 with rd_ready=1 -> rd_valid first in cycle 3 after accept, data 0x11,0x22,0x33,0x44 back-to-back, rd_last and done on 0x44.
3. Fill line 5 with rd_ready low for 10 cycles after the first rd_valid -> no more than 2 reads issued ahead, then all 4 beats delivered in order with none lost.
4. Writeback line 255 (last line) with wd_valid toggling every cycle -> mem_we only after accepted beats, waddr 1020..1023, waddr MSB=0.
5. Assert rst_n low after 2 fill beats delivered -> all outputs at reset values in the same cycle. After release req_ready=1, and a new fill of line 0 returns mem[0..3].
6. With MEM_LINE_ENGINE_CWF_EN, fill line 3 with req_word=2 -> raddr 14,15,12,13, rd_last on mem[13] data. Without the macro -> raddr 12,13,14,15.

Source files
------------

// File: rtl/mem_line_engine.sv
// Cache-line mover for the single-write/single-read synchronous Memory: writebacks stream beats to
// write_en/waddr/wdata, fills issue raddr and buffer returns in a 2-entry FIFO. Option: MEM_LINE_ENGINE_CWF_EN.
module mem_line_engine #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 64,
    parameter int BEATS  = 4,
    localparam int BW     = $clog2(BEATS),
    localparam int LINE_W = ADDR_W - BW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [LINE_W-1:0] req_line,
    input  logic [BW-1:0]     req_word,
    input  logic              wd_valid,
    output logic              wd_ready,
    input  logic [DATA_W-1:0] wd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_last,
    output logic              done,
    output logic              mem_we,
    output logic [ADDR_W:0]   mem_waddr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [ADDR_W:0]   mem_raddr,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

    localparam logic [BW:0] LAST_CNT = (BW+1)'(BEATS - 1);
    localparam logic [BW:0] FULL_CNT = (BW+1)'(BEATS);

    state_t              state_reg, state_next;
    logic [LINE_W-1:0]   line_reg;
    logic [BW-1:0]       beat_reg;
    logic [BW:0]         cnt_reg;
    logic                wlast_reg;
    logic                mem_we_reg;
    logic [ADDR_W:0]     mem_waddr_reg;
    logic [DATA_W-1:0]   mem_wdata_reg;
    logic [ADDR_W:0]     raddr_hold_reg;
    logic                inflight_reg;
    logic                inflight_last_reg;
    logic                wr_ptr_reg;
    logic                rd_ptr_reg;
    logic [1:0]          fifo_cnt_reg;

    logic                accept;
    logic                wd_hs;
    logic                issue;
    logic                issue_last;
    logic                push;
    logic                pop;
    logic [2:0]          occupancy;
    logic [ADDR_W:0]     cur_addr;
    logic [BW-1:0]       start_beat;

`ifdef MEM_LINE_ENGINE_CWF_EN
    assign start_beat = req_word;
`else
    logic unused_req_word;
    assign unused_req_word = ^req_word;
    assign start_beat      = '0;
`endif

    assign cur_addr   = {1'b0, line_reg, beat_reg};
    assign accept     = req_valid && req_ready;
    assign wd_hs      = wd_valid && wd_ready;
    assign issue_last = (cnt_reg == LAST_CNT);
    assign rd_valid   = (fifo_cnt_reg != 2'd0);
    assign pop        = (state_reg == READ) && rd_valid && rd_ready;
    assign push       = inflight_reg;
    // A read in flight already owns a FIFO slot, so it counts toward the two-entry limit.
    assign occupancy  = {1'b0, fifo_cnt_reg} + {2'b00, inflight_reg};

    always_comb begin
        state_next = state_reg;
        req_ready  = 1'b0;
        wd_ready   = 1'b0;
        done       = 1'b0;
        issue      = 1'b0;
        unique case (state_reg)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid)
                    state_next = req_write ? WRITE : READ;
            end
            WRITE: begin
                wd_ready = (cnt_reg != FULL_CNT);
                if (mem_we_reg && wlast_reg) begin
                    done       = 1'b1;
                    state_next = IDLE;
                end
            end
            READ: begin
                issue = (cnt_reg != FULL_CNT) && ((occupancy - {2'b00, pop}) < 3'd2);
                if (pop && rd_last) begin
                    done       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg         <= IDLE;
            line_reg          <= '0;
            beat_reg          <= '0;
            cnt_reg           <= '0;
            wlast_reg         <= 1'b0;
            mem_we_reg        <= 1'b0;
            mem_waddr_reg     <= '0;
            mem_wdata_reg     <= '0;
            raddr_hold_reg    <= '0;
            inflight_reg      <= 1'b0;
            inflight_last_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                line_reg <= req_line;
                beat_reg <= req_write ? '0 : start_beat;
                cnt_reg  <= '0;
            end else if (wd_hs || issue) begin
                // beat_reg wraps naturally, which gives the critical-word-first order for free.
                beat_reg <= beat_reg + BW'(1);
                cnt_reg  <= cnt_reg + (BW+1)'(1);
            end
            mem_we_reg <= wd_hs;
            wlast_reg  <= wd_hs && issue_last;
            if (wd_hs) begin
                mem_waddr_reg <= cur_addr;
                mem_wdata_reg <= wd_data;
            end
            inflight_reg <= issue;
            if (issue) begin
                raddr_hold_reg    <= cur_addr;
                inflight_last_reg <= issue_last;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg   <= 1'b0;
            rd_ptr_reg   <= 1'b0;
            fifo_cnt_reg <= 2'd0;
        end else begin
            if (push)
                wr_ptr_reg <= ~wr_ptr_reg;
            if (pop)
                rd_ptr_reg <= ~rd_ptr_reg;
            fifo_cnt_reg <= fifo_cnt_reg + {1'b0, push} - {1'b0, pop};
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fifo
            logic [DATA_W-1:0] data_reg;
            logic              last_reg;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    data_reg <= '0;
                    last_reg <= 1'b0;
                end else if (push && (wr_ptr_reg == 1'(gi))) begin
                    data_reg <= mem_rdata;
                    last_reg <= inflight_last_reg;
                end
            end
        end
    endgenerate

    assign rd_data   = rd_ptr_reg ? g_fifo[1].data_reg : g_fifo[0].data_reg;
    assign rd_last   = rd_ptr_reg ? g_fifo[1].last_reg : g_fifo[0].last_reg;
    // Holding the last address keeps the memory read port quiet between issues.
    assign mem_raddr = issue ? cur_addr : raddr_hold_reg;
    assign mem_we    = mem_we_reg;
    assign mem_waddr = mem_waddr_reg;
    assign mem_wdata = mem_wdata_reg;

endmodule
